mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Sequences the single-ported unified memory shared by the Fetch stage instruction port and the Memory stage data port. Grants one requester at a time. Drives the memory request/ready handshake and returns read data with a one-cycle valid pulse. Generates per-requester stalls and discards fetch responses killed by a branch/jump redirect. Data side has priority; a starvation guard bounds how long fetch can wait.

Parameters:
StarveLimit, 4, consecutive data grants made while IReq is pending before fetch is forced to win (1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
IReq  in  1  fetch request; level, held until IValid or IFlush
IAddr  in  32  fetch address; stable while IReq high
IFlush  in  1  one-cycle redirect pulse; kills any outstanding fetch response
IData  out  32  fetched instruction word
IValid  out  1  one-cycle pulse; IData valid
IStall  out  1  IReq & ~IValid (combinational)
DReq  in  1  data request; level, held until DValid
DWrite  in  1  1 = store, 0 = load
DAddr  in  32  data address
DWData  in  32  store data
DByteEn  in  4  store byte enables
DRData  out  32  load data
DValid  out  1  one-cycle pulse; load data returned or store accepted
DStall  out  1  DReq & ~DValid (combinational)
MemReq  out  1  memory request, registered
MemWrite  out  1  registered copy of granted DWrite (0 for fetch)
MemAddr  out  32  registered granted address
MemWData  out  32  registered store data
MemByteEn  out  4  registered byte enables (4'hF for fetch)
MemRData  in  32  memory read data, valid when MemReady high
MemReady  in  1  memory completes the access in this cycle

Behaviour:
- FSM states: IDLE, ISSUE, RESP. Owner register: OWN_I / OWN_D. Drop flag. Starve counter: 4 bits.
- Reset (reset low, async): state IDLE; MemReq, MemWrite, IValid, DValid, drop flag and starve counter cleared to 0; MemAddr, MemWData, IData and DRData cleared to 0; MemByteEn 0. Any in-flight memory access is abandoned; the memory model must tolerate this.
- IDLE:
  - No request: remain in IDLE.
  - Arbitration: if IReq and (~DReq or starve == StarveLimit), grant I; else if DReq, grant D.
  - On grant: latch address, data and byte enables into the Mem* registers. Set MemReq=1 and go to ISSUE.
  - Starve counter: a D grant while IReq is high increments it, saturating at StarveLimit. An I grant clears it to 0.
  - IFlush while in IDLE has no effect.
- ISSUE: hold MemReq and all Mem* outputs stable until MemReady=1.
  - On the MemReady edge: capture MemRData into IData or DRData, according to owner. Drop MemReq and go to RESP.
  - A store does not update DRData.
- RESP (exactly one cycle, no arbitration):
  - Owner D: DValid=1.
  - Owner I: IValid=1 unless the drop flag is set or IFlush is high this cycle. IFlush gates IValid combinationally.
  - Then go to IDLE and clear the drop flag.
- Drop flag: set by IFlush while in ISSUE with owner I. The memory access still completes, but the response is discarded.
- IFlush during a D transaction: ignored.
- Latency: grant edge → MemReq at the next cycle. With zero-wait memory (MemReady is combinational in the same cycle as MemReq), the valid pulse appears 2 cycles after the grant. Minimum spacing is 3 cycles per access.
- A requester may deassert its request in its own Valid cycle. Because RESP does not arbitrate, no duplicate issue occurs.
- Simultaneous IReq and DReq with the counter below the limit: D wins.
- Counter at StarveLimit with both requesting: I wins.
- MemReady while not in ISSUE: ignored.

Decomposition:
- Shared package: state encoding (IDLE=2'b00, ISSUE=2'b01, RESP=2'b10), owner encoding (OWN_I=1'b0, OWN_D=1'b1), the 4'hF fetch byte-enable constant, and the 32-bit word width constant.
- One natural sub-module: arb_starve_counter (saturating counter with inc, clr and at_limit). The FSM and data registers stay in the top level.

Test Plan:
- Fetch only: IReq=1, IAddr=32'h0000_0010, MemReady tied 1, memory returns 32'h2001_0004 → MemReq high 1 cycle with MemAddr=32'h10 and MemByteEn=4'hF. IValid pulses 2 cycles after the grant with IData=32'h2001_0004. IStall is high until that cycle.
- Conflict: IReq and DReq rise together, DWrite=0, DAddr=32'h100 → data is served first (DValid); fetch is granted at the next IDLE. The starve counter reads 1, then clears.
- Starvation: DReq held high continuously, IReq held high, StarveLimit=4 → grant order D,D,D,D,I,D… IValid occurs after the 4th DValid.
- Flush: fetch granted, MemReady held 0 for 3 cycles, IFlush pulsed in ISSUE, then MemReady=1 → no IValid, IData register updated, state returns to IDLE. The next fetch to the new IAddr completes normally.
- Store plus wait states: DWrite=1, DByteEn=4'b0011, DWData=32'hDEAD_BEEF, MemReady=0 for 2 cycles → MemWrite, MemWData and MemByteEn are held stable throughout. DValid pulses once, DRData is unchanged, DStall is high until DValid.
- Async reset in ISSUE: reset driven low mid-cycle → MemReq, IValid and DValid drop immediately. After reset is released, a pending IReq is granted from IDLE with the counter at 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    localparam int WORD_W = 32;
    localparam logic [3:0] FETCH_BE = 4'hF;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // One memory command as presented on the Mem* outputs.
    typedef struct packed {
        logic       write;
        word_t      addr;
        word_t      wdata;
        logic [3:0] be;
    } mem_cmd_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of data grants made while a fetch is waiting.
// Latency: count updates on the clock after inc/clr; at_limit is combinational from the count.
// Backpressure: none; clr wins over inc.
module arb_starve_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [3:0] LIM = 4'(LIMIT);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + 4'd1;
        end
    end

    assign at_limit = (count == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one single-ported memory, data first with a starvation guard.
// Latency: Mem* registered one cycle after grant; Valid pulses one cycle after MemReady (2 cycles min from grant).
// Backpressure: requesters hold their level requests; stalls are Req & ~Valid; memory stalls via MemReady.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned StarveLimit = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        IReq,
    input  logic [31:0] IAddr,
    input  logic        IFlush,
    output logic [31:0] IData,
    output logic        IValid,
    output logic        IStall,

    input  logic        DReq,
    input  logic        DWrite,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWData,
    input  logic [3:0]  DByteEn,
    output logic [31:0] DRData,
    output logic        DValid,
    output logic        DStall,

    output logic        MemReq,
    output logic        MemWrite,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemByteEn,
    input  logic [31:0] MemRData,
    input  logic        MemReady
);

    arb_state_t state;
    owner_t     owner;
    mem_cmd_t   cmd_q;
    mem_cmd_t   grant_cmd;
    logic       drop;
    logic       ivalid_q;
    logic       at_limit;
    logic       grant_i;
    logic       grant_d;

    assign grant_i = (state == IDLE) && IReq && (!DReq || at_limit);
    assign grant_d = (state == IDLE) && DReq && !grant_i;

    arb_starve_counter #(
        .LIMIT (StarveLimit)
    ) u_starve (
        .clk      (clk),
        .rst_n    (reset),
        .inc      (grant_d && IReq),
        .clr      (grant_i),
        .at_limit (at_limit)
    );

    always_comb begin
        grant_cmd = '0;
        if (grant_i) begin
            grant_cmd.write = 1'b0;
            grant_cmd.addr  = IAddr;
            grant_cmd.wdata = '0;
            grant_cmd.be    = FETCH_BE;
        end else begin
            grant_cmd.write = DWrite;
            grant_cmd.addr  = DAddr;
            grant_cmd.wdata = DWData;
            grant_cmd.be    = DByteEn;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= OWN_I;
            cmd_q    <= '0;
            MemReq   <= 1'b0;
            drop     <= 1'b0;
            ivalid_q <= 1'b0;
            DValid   <= 1'b0;
            IData    <= '0;
            DRData   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ivalid_q <= 1'b0;
                    DValid   <= 1'b0;
                    if (grant_i || grant_d) begin
                        owner  <= grant_i ? OWN_I : OWN_D;
                        cmd_q  <= grant_cmd;
                        MemReq <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A redirect during a fetch still lets the access finish; only its response is discarded.
                    if ((owner == OWN_I) && IFlush) begin
                        drop <= 1'b1;
                    end
                    if (MemReady) begin
                        MemReq <= 1'b0;
                        state  <= RESP;
                        if (owner == OWN_I) begin
                            IData    <= MemRData;
                            ivalid_q <= !(drop || IFlush);
                        end else begin
                            if (!cmd_q.write) begin
                                DRData <= MemRData;
                            end
                            DValid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    ivalid_q <= 1'b0;
                    DValid   <= 1'b0;
                    drop     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign MemWrite  = cmd_q.write;
    assign MemAddr   = cmd_q.addr;
    assign MemWData  = cmd_q.wdata;
    assign MemByteEn = cmd_q.be;

    // A flush arriving in the response cycle itself still kills the pulse.
    assign IValid = ivalid_q && !IFlush;
    assign IStall = IReq && !IValid;
    assign DStall = DReq && !DValid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        IReq = 1'b0, IFlush = 1'b0, DReq = 1'b0, DWrite = 1'b0, MemReady = 1'b0;
    logic [31:0] IAddr = '0, DAddr = '0, DWData = '0;
    logic [3:0]  DByteEn = 4'hF;
    logic [31:0] IData, DRData, MemAddr, MemWData, MemRData;
    logic        IValid, IStall, DValid, DStall, MemReq, MemWrite;
    logic [3:0]  MemByteEn;

    int checks = 0;
    int fails  = 0;

    logic        ovr_en = 1'b0;
    logic [31:0] ovr_dat = '0;

    mem_port_arbiter #(.StarveLimit(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .IReq(IReq), .IAddr(IAddr), .IFlush(IFlush), .IData(IData), .IValid(IValid), .IStall(IStall),
        .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWData(DWData), .DByteEn(DByteEn),
        .DRData(DRData), .DValid(DValid), .DStall(DStall),
        .MemReq(MemReq), .MemWrite(MemWrite), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemByteEn(MemByteEn), .MemRData(MemRData), .MemReady(MemReady)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory stub: contents are a fixed function of the address; garbage when not ready.
    assign MemRData = !MemReady ? 32'h0BAD_0BAD : (ovr_en ? ovr_dat : hash(MemAddr));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          m_busy, m_done, m_killed, m_who;  // m_who: 1 = data requester
    logic        m_write;
    logic [31:0] m_addr, m_wdata, m_idata, m_drdata;
    logic [3:0]  m_be;
    int          m_starve;

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_killed = 0; m_who = 0;
        m_write = 0; m_addr = '0; m_wdata = '0; m_be = '0;
        m_idata = '0; m_drdata = '0; m_starve = 0;
    endtask

    task automatic m_start(input bit who);
        m_busy = 1; m_done = 0; m_killed = 0; m_who = who;
        m_addr  = who ? DAddr : IAddr;
        m_write = who ? DWrite : 1'b0;
        m_wdata = who ? DWData : 32'h0;
        m_be    = who ? DByteEn : 4'hF;
    endtask

    initial begin : compare
        logic ei, ed;
        model_reset();
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                model_reset();
            end else begin
                ei = m_busy && m_done && !m_who && !m_killed && !IFlush;
                ed = m_busy && m_done && m_who;
                chk("MemReq",    32'(MemReq),    32'(m_busy && !m_done));
                chk("MemWrite",  32'(MemWrite),  32'(m_write));
                chk("MemAddr",   MemAddr,        m_addr);
                chk("MemWData",  MemWData,       m_wdata);
                chk("MemByteEn", 32'(MemByteEn), 32'(m_be));
                chk("IValid",    32'(IValid),    32'(ei));
                chk("DValid",    32'(DValid),    32'(ed));
                chk("IData",     IData,          m_idata);
                chk("DRData",    DRData,         m_drdata);
                chk("IStall",    32'(IStall),    32'(IReq && !ei));
                chk("DStall",    32'(DStall),    32'(DReq && !ed));
                if (m_busy && m_done) begin
                    m_busy = 0;
                end else if (m_busy) begin
                    if (!m_who && IFlush) m_killed = 1;
                    if (MemReady) begin
                        m_done = 1;
                        if (!m_who) m_idata = ovr_en ? ovr_dat : hash(m_addr);
                        else if (!m_write) m_drdata = ovr_en ? ovr_dat : hash(m_addr);
                    end
                end else if (IReq && (!DReq || m_starve == LIMIT)) begin
                    m_start(0);
                    m_starve = 0;
                end else if (DReq) begin
                    m_start(1);
                    if (IReq && m_starve < LIMIT) m_starve++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1 IFlush = 1'b0;
        #1;
    endtask

    task automatic wait_sig(input bit data_side, input string name, output int n);
        n = 0;
        while ((data_side ? DValid : IValid) !== 1'b1) begin
            if (n == 60) begin
                checks++; fails++;
                $display("FAIL %s: timeout after %0d cycles, expected a valid pulse", name, n);
                break;
            end
            step();
            n++;
        end
    endtask

    initial begin : main
        int    n, ndv;
        bit    got_i, prev_req;
        string order;

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_MemReq",    32'(MemReq),    32'h0);
        chk("rst_MemWrite",  32'(MemWrite),  32'h0);
        chk("rst_MemAddr",   MemAddr,        32'h0);
        chk("rst_MemByteEn", 32'(MemByteEn), 32'h0);
        chk("rst_IValid",    32'(IValid),    32'h0);
        chk("rst_DValid",    32'(DValid),    32'h0);
        chk("rst_IData",     IData,          32'h0);
        chk("rst_DRData",    DRData,         32'h0);

        // Fetch only, zero-wait memory.
        IReq = 1; IAddr = 32'h10; MemReady = 1; ovr_en = 1; ovr_dat = 32'h2001_0004;
        #1 chk("f_stall_pre", 32'(IStall), 32'h1);
        step();
        chk("f_memreq",  32'(MemReq),    32'h1);
        chk("f_memaddr", MemAddr,        32'h10);
        chk("f_be",      32'(MemByteEn), 32'hF);
        chk("f_noval",   32'(IValid),    32'h0);
        step();
        chk("f_ivalid",  32'(IValid),    32'h1);
        chk("f_idata",   IData,          32'h2001_0004);
        chk("f_nostall", 32'(IStall),    32'h0);
        chk("f_reqdone", 32'(MemReq),    32'h0);
        IReq = 0;
        step();
        ovr_en = 0;
        chk("f_pulse", 32'(IValid), 32'h0);

        // Conflict: data served first, fetch at the next idle.
        IReq = 1; IAddr = 32'h20; DReq = 1; DWrite = 0; DAddr = 32'h100; DByteEn = 4'hF; DWData = 32'h0;
        step();
        chk("c_first_addr", MemAddr, 32'h100);
        wait_sig(1, "c_dvalid", n);
        DReq = 0;
        wait_sig(0, "c_ivalid", n);
        chk("c_gap", 32'(n), 32'd3);
        IReq = 0;

        // Starvation guard: both held, expect D,D,D,D,I,D.
        IReq = 1; IAddr = 32'h40; DReq = 1; DAddr = 32'h200;
        order = ""; ndv = 0; got_i = 0; prev_req = MemReq;
        for (int c = 0; c < 60; c++) begin
            step();
            if (MemReq && !prev_req) begin
                if (MemAddr == 32'h40) order = {order, "I"};
                else order = {order, "D"};
            end
            prev_req = MemReq;
            if (DValid) ndv++;
            if (IValid && !got_i) begin
                got_i = 1;
                chk("s_dvalids_before_i", 32'(ndv), 32'd4);
                IReq = 0;
            end
            if (order.len() >= 6) break;
        end
        checks++;
        if (order != "DDDDID") begin
            fails++;
            $display("FAIL s_order: got %s, expected DDDDID", order);
        end
        wait_sig(1, "s_dend", n);
        DReq = 0;
        step();

        // Flush during a waited fetch.
        MemReady = 0; IReq = 1; IAddr = 32'h80;
        step();
        chk("fl_req", 32'(MemReq), 32'h1);
        step();
        IFlush = 1; IAddr = 32'h84;
        step();
        step();
        MemReady = 1;
        step();
        chk("fl_no_ivalid", 32'(IValid), 32'h0);
        chk("fl_idata",     IData,       hash(32'h80));
        step();
        step();
        chk("fl_readdr", MemAddr, 32'h84);
        step();
        chk("fl_ivalid2", 32'(IValid), 32'h1);
        chk("fl_idata2",  IData,       hash(32'h84));
        IReq = 0;

        // Store with two wait states.
        DReq = 1; DWrite = 1; DAddr = 32'h300; DWData = 32'hDEAD_BEEF; DByteEn = 4'b0011; MemReady = 0;
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            chk("st_write", 32'(MemWrite),  32'h1);
            chk("st_wdata", MemWData,       32'hDEAD_BEEF);
            chk("st_be",    32'(MemByteEn), 32'h3);
            chk("st_stall", 32'(DStall),    32'h1);
            if (k == 2) MemReady = 1;
            step();
        end
        chk("st_dvalid",   32'(DValid), 32'h1);
        chk("st_drdata",   DRData,      hash(32'h200));
        chk("st_nostall",  32'(DStall), 32'h0);
        DReq = 0; DWrite = 0;
        step();
        chk("st_pulse", 32'(DValid), 32'h0);

        // Asynchronous reset while a fetch is in ISSUE.
        IReq = 1; IAddr = 32'h500; MemReady = 0;
        step();
        step();
        chk("ar_req_before", 32'(MemReq), 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("ar_memreq", 32'(MemReq), 32'h0);
        chk("ar_ivalid", 32'(IValid), 32'h0);
        chk("ar_dvalid", 32'(DValid), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        step();
        chk("ar_regrant", 32'(MemReq), 32'h1);
        chk("ar_addr",    MemAddr,     32'h500);
        MemReady = 1;
        step();
        chk("ar_ivalid2", 32'(IValid), 32'h1);
        IReq = 0;

        // Random traffic, checked every cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            step();
            if ($urandom_range(0, 15) == 0) begin
                IFlush = 1;
                IAddr  = 32'($urandom_range(0, 1023)) << 2;
                IReq   = ($urandom_range(0, 3) != 0);
            end else if (IValid) begin
                IReq  = $urandom_range(0, 1);
                IAddr = 32'($urandom_range(0, 1023)) << 2;
            end else if (!IReq) begin
                IReq  = ($urandom_range(0, 2) == 0);
                IAddr = 32'($urandom_range(0, 1023)) << 2;
            end
            if (DValid || !DReq) begin
                DReq    = ($urandom_range(0, 2) != 0);
                DWrite  = $urandom_range(0, 1);
                DAddr   = 32'($urandom_range(0, 1023)) << 2;
                DWData  = $urandom;
                DByteEn = 4'($urandom_range(0, 15));
            end
            MemReady = ($urandom_range(0, 9) < 6);
        end
        IReq = 0; DReq = 0; MemReady = 1;
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

endmodule
